// File: rtl/ivs_cfg_arb_if.sv
// Requester handshake and AHB-lite master bundle for the config-space arbiter.
// The master modport is the arbiter's view; slave is the requester/slave side.
interface ivs_cfg_arb_if;
    logic        req0_vld;
    logic        req0_wr;
    logic [11:0] req0_addr;
    logic [31:0] req0_wdata;
    logic        req0_ack;
    logic        req0_done;
    logic        req1_vld;
    logic        req1_wr;
    logic [11:0] req1_addr;
    logic [31:0] req1_wdata;
    logic        req1_ack;
    logic        req1_done;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hready_in;
    logic        hready;
    logic [31:0] hrdata;

    modport master (
        input  req0_vld, req0_wr, req0_addr, req0_wdata,
        input  req1_vld, req1_wr, req1_addr, req1_wdata,
        output req0_ack, req0_done, req1_ack, req1_done,
        output rsp_rdata, rsp_err,
        output hsel, htrans, hwrite, haddr, hwdata, hsize, hburst, hprot, hready_in,
        input  hready, hrdata
    );

    modport slave (
        output req0_vld, req0_wr, req0_addr, req0_wdata,
        output req1_vld, req1_wr, req1_addr, req1_wdata,
        input  req0_ack, req0_done, req1_ack, req1_done,
        input  rsp_rdata, rsp_err,
        input  hsel, htrans, hwrite, haddr, hwdata, hsize, hburst, hprot, hready_in,
        output hready, hrdata
    );
endinterface

// File: rtl/ivs_cfg_arb.sv
// Two-requester round-robin arbiter issuing single AHB-lite config transfers.
// Define IVS_CFG_ARB_TIMEOUT_EN to abort a stalled data phase after TO_CYC cycles.
module ivs_cfg_arb #(
    parameter int TO_CYC = 16
) (
    input  logic          hclk,
    input  logic          hrst,
    ivs_cfg_arb_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      state_q, state_d;
    logic        last_q;
    logic        gnt_q, gnt_d;
    logic        wr_q;
    logic [9:0]  addr_q;
    logic [31:0] wdata_q;
    logic        done0_q, done1_q;
    logic [31:0] rdata_q;
    logic        any_vld;
    logic        fin;
    logic        to_hit;

    assign any_vld = bus.req0_vld | bus.req1_vld;
    // Tie goes to whoever did not win last; otherwise the lone requester wins.
    assign gnt_d   = (bus.req0_vld && bus.req1_vld) ? ~last_q : bus.req1_vld;
    assign fin     = (state_q == DATA) && (bus.hready || to_hit);

`ifdef IVS_CFG_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TO_CYC + 1);
    logic [CNT_W-1:0] to_cnt_q;
    logic             err_q;

    always_ff @(posedge hclk) begin
        if (hrst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == ADDR)
                to_cnt_q <= '0;
            else if (state_q == DATA && !bus.hready)
                to_cnt_q <= to_cnt_q + CNT_W'(1);
            if (fin)
                err_q <= to_hit;
        end
    end

    // hready on the limit cycle keeps the transfer a normal completion.
    assign to_hit      = (state_q == DATA) && !bus.hready && (to_cnt_q == CNT_W'(TO_CYC - 1));
    assign bus.rsp_err = err_q;
`else
    assign to_hit      = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge hclk) begin
        if (hrst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            done0_q <= fin && !gnt_q;
            done1_q <= fin && gnt_q;
            if (state_q == IDLE && any_vld) begin
                gnt_q   <= gnt_d;
                last_q  <= gnt_d;
                wr_q    <= gnt_d ? bus.req1_wr : bus.req0_wr;
                addr_q  <= gnt_d ? bus.req1_addr[11:2] : bus.req0_addr[11:2];
                if (gnt_d)
                    wdata_q <= bus.req1_wr ? bus.req1_wdata : '0;
                else
                    wdata_q <= bus.req0_wr ? bus.req0_wdata : '0;
            end
            if (fin)
                rdata_q <= (wr_q || to_hit) ? '0 : bus.hrdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.hsel     = 1'b0;
        bus.htrans   = 2'b00;
        bus.hwrite   = 1'b0;
        bus.haddr    = '0;
        bus.hsize    = 3'b000;
        bus.hburst   = 3'b000;
        bus.hprot    = 4'b0000;
        bus.hwdata   = '0;
        bus.req0_ack = 1'b0;
        bus.req1_ack = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_vld)
                    state_d = ADDR;
            end
            ADDR: begin
                state_d      = DATA;
                bus.hsel     = 1'b1;
                bus.htrans   = 2'b10;
                bus.hwrite   = wr_q;
                bus.haddr    = {20'b0, addr_q, 2'b00};
                bus.hsize    = 3'b010;
                bus.hprot    = 4'b0011;
                bus.req0_ack = !gnt_q;
                bus.req1_ack = gnt_q;
            end
            DATA: begin
                bus.hwdata = wdata_q;
                if (bus.hready || to_hit)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.hready_in = 1'b1;
    assign bus.req0_done = done0_q;
    assign bus.req1_done = done1_q;
    assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_ivs_cfg_arb.sv
// Scoreboard bench for ivs_cfg_arb: directed transfers push expected acks/dones,
// a negedge monitor pops and compares them as the DUT pulses.
module tb_ivs_cfg_arb;
    typedef struct {
        logic        id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic hclk;
    logic hrst;
    int   n_vec;
    int   n_err;
    logic ack_q[$];
    exp_t done_q[$];
    logic mon_id;
    exp_t mon_exp;

    ivs_cfg_arb_if bus();

    ivs_cfg_arb #(.TO_CYC(16)) dut (
        .hclk(hclk),
        .hrst(hrst),
        .bus (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic exp_done(input logic id, input logic [31:0] rd, input logic er);
        exp_t e;
        e.id    = id;
        e.rdata = rd;
        e.err   = er;
        done_q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, 32'({bus.hsel, bus.htrans, bus.hwrite, bus.hsize, bus.hburst, bus.hprot,
                                 bus.req0_ack, bus.req1_ack, bus.req0_done, bus.req1_done, bus.rsp_err}), 32'd0);
        chk({tag, "_haddr"}, bus.haddr, 32'd0);
        chk({tag, "_hwdata"}, bus.hwdata, 32'd0);
        chk({tag, "_rdata"}, bus.rsp_rdata, 32'd0);
        chk({tag, "_hready_in"}, 32'(bus.hready_in), 32'd1);
    endtask

    always @(negedge hclk) begin
        if (bus.req0_ack || bus.req1_ack) begin
            if (ack_q.size() == 0)
                chk("unexpected_ack", 32'({bus.req1_ack, bus.req0_ack}), 32'd0);
            else begin
                mon_id = ack_q.pop_front();
                chk("ack_id", 32'({bus.req1_ack, bus.req0_ack}), mon_id ? 32'd2 : 32'd1);
            end
        end
        if (bus.req0_done || bus.req1_done) begin
            if (done_q.size() == 0)
                chk("unexpected_done", 32'({bus.req1_done, bus.req0_done}), 32'd0);
            else begin
                mon_exp = done_q.pop_front();
                chk("done_id", 32'({bus.req1_done, bus.req0_done}), mon_exp.id ? 32'd2 : 32'd1);
                chk("done_rdata", bus.rsp_rdata, mon_exp.rdata);
                chk("done_err", 32'(bus.rsp_err), 32'(mon_exp.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        hrst  = 1'b1;
        bus.req0_vld = 0; bus.req0_wr = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_vld = 0; bus.req1_wr = 0; bus.req1_addr = '0; bus.req1_wdata = '0;
        bus.hready = 1'b0; bus.hrdata = '0;
        repeat (3) tick();
        chk_reset_outputs("rst");
        hrst = 1'b0;
        tick();

        // req0 write with one wait state
        bus.req0_vld = 1; bus.req0_wr = 1; bus.req0_addr = 12'h100; bus.req0_wdata = 32'hA5A5_0001;
        ack_q.push_back(1'b0);
        exp_done(1'b0, 32'h0, 1'b0);
        tick();
        chk("wr_addr_htrans", 32'(bus.htrans), 32'd2);
        chk("wr_addr_haddr", bus.haddr, 32'h100);
        chk("wr_addr_attr", 32'({bus.hsel, bus.hwrite, bus.hsize, bus.hburst, bus.hprot, bus.hready_in}),
            32'({1'b1, 1'b1, 3'b010, 3'b000, 4'b0011, 1'b1}));
        bus.req0_vld = 0; bus.req0_wdata = 32'h0;
        tick();
        chk("wr_d1_htrans", 32'({bus.hsel, bus.htrans}), 32'd0);
        chk("wr_d1_hwdata", bus.hwdata, 32'hA5A5_0001);
        tick();
        chk("wr_d2_hwdata", bus.hwdata, 32'hA5A5_0001);
        bus.hready = 1;
        tick();
        chk("wr_idle_hwdata", bus.hwdata, 32'h0);
        bus.hready = 0;
        tick();

        // req1 read, zero wait states, low address bits ignored
        bus.req1_vld = 1; bus.req1_wr = 0; bus.req1_addr = 12'h11F;
        ack_q.push_back(1'b1);
        exp_done(1'b1, 32'h1234_5678, 1'b0);
        tick();
        chk("rd_haddr", bus.haddr, 32'h11C);
        chk("rd_hwrite", 32'(bus.hwrite), 32'd0);
        bus.req1_vld = 0;
        bus.hready = 1; bus.hrdata = 32'h1234_5678;
        tick();
        tick();
        bus.hready = 0; bus.hrdata = 32'hFFFF_FFFF;
        tick();
        tick();
        chk("rd_rdata_hold", bus.rsp_rdata, 32'h1234_5678);

        // round robin from reset, both requesters valid throughout
        hrst = 1; tick(); tick(); hrst = 0;
        bus.req0_vld = 1; bus.req0_wr = 1; bus.req0_addr = 12'h207; bus.req0_wdata = 32'h0000_0207;
        bus.req1_vld = 1; bus.req1_wr = 0; bus.req1_addr = 12'h040;
        bus.hready = 1; bus.hrdata = 32'hCAFE_0001;
        for (int i = 0; i < 4; i++) begin
            ack_q.push_back(i[0]);
            exp_done(i[0], i[0] ? 32'hCAFE_0001 : 32'h0, 1'b0);
        end
        tick();
        chk("rr_g0_haddr", bus.haddr, 32'h204);
        tick();
        chk("rr_g0_hwdata", bus.hwdata, 32'h0000_0207);
        tick();
        tick();
        chk("rr_g1_haddr", bus.haddr, 32'h040);
        repeat (8) tick();
        bus.req0_vld = 0; bus.req1_vld = 0;
        bus.hready = 0; bus.hrdata = 32'h0;
        repeat (3) tick();

        // req0 pulses while req1 sits in its data phase
        bus.req1_vld = 1; bus.req1_wr = 0; bus.req1_addr = 12'h080;
        ack_q.push_back(1'b1);
        exp_done(1'b1, 32'h0BAD_F00D, 1'b0);
        tick();
        bus.req1_vld = 0;
        tick();
        bus.req0_vld = 1; bus.req0_wr = 1; bus.req0_addr = 12'h0F0;
        tick();
        bus.req0_vld = 0;
        bus.hready = 1; bus.hrdata = 32'h0BAD_F00D;
        tick();
        bus.hready = 0; bus.hrdata = 32'h0;
        repeat (3) tick();
        chk("drop_rdata_hold", bus.rsp_rdata, 32'h0BAD_F00D);

        // stalled data phase
        bus.req0_vld = 1; bus.req0_wr = 1; bus.req0_addr = 12'h3F0; bus.req0_wdata = 32'hDEAD_0016;
        ack_q.push_back(1'b0);
`ifdef IVS_CFG_ARB_TIMEOUT_EN
        exp_done(1'b0, 32'h0, 1'b1);
`endif
        tick();
        bus.req0_vld = 0;
        tick();
        repeat (15) tick();
        chk("to_d16_hwdata", bus.hwdata, 32'hDEAD_0016);
        tick();
`ifdef IVS_CFG_ARB_TIMEOUT_EN
        chk("to_exit_hwdata", bus.hwdata, 32'h0);
        tick();
        chk("to_err_hold", 32'(bus.rsp_err), 32'd1);
        chk("to_rdata_zero", bus.rsp_rdata, 32'h0);
        bus.req0_vld = 1; bus.req0_wr = 1; bus.req0_addr = 12'h3F4; bus.req0_wdata = 32'hDEAD_0017;
        ack_q.push_back(1'b0);
        tick();
        bus.req0_vld = 0;
        tick();
        tick();
        chk("pre_rst_hwdata", bus.hwdata, 32'hDEAD_0017);
`else
        repeat (20) tick();
        chk("stall_hwdata", bus.hwdata, 32'hDEAD_0016);
`endif

        // reset in the middle of a data phase, then a tie
        hrst = 1;
        tick();
        hrst = 0;
        chk_reset_outputs("mid_rst");
        tick();
        bus.req0_vld = 1; bus.req0_wr = 0; bus.req0_addr = 12'h010;
        bus.req1_vld = 1; bus.req1_wr = 0; bus.req1_addr = 12'h020;
        ack_q.push_back(1'b0);
        exp_done(1'b0, 32'h5555_AAAA, 1'b0);
        tick();
        chk("post_rst_haddr", bus.haddr, 32'h010);
        bus.req0_vld = 0; bus.req1_vld = 0;
        bus.hready = 1; bus.hrdata = 32'h5555_AAAA;
        tick();
        tick();
        bus.hready = 0; bus.hrdata = 32'h0;
        repeat (3) tick();

        chk("ack_q_empty", 32'(ack_q.size()), 32'd0);
        chk("done_q_empty", 32'(done_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ivs_cfg_arb.md
IVS_CFG_ARB -- requirements
Module: ivs_cfg_arb

Interface
REQ-001 Parameter: TO_CYC, 16, data-phase timeout limit in cycles (used only with IVS_CFG_ARB_TIMEOUT_EN).
REQ-002 Ports, in order (name  direction  width  meaning):
 hclk  in  1  sole clock, rising edge.
 hrst  in  1  reset, synchronous, active-high.
 req0_vld / req1_vld  in  1  requester N has a pending transfer.
 req0_wr / req1_wr  in  1  1 = write, 0 = read.
 req0_addr / req1_addr  in  12  byte offset, bits [1:0] ignored (driven 0 on haddr).
 req0_wdata / req1_wdata  in  32  write data.
 req0_ack / req1_ack  out  1  one-cycle pulse: request accepted (address phase issued).
 req0_done / req1_done  out  1  one-cycle pulse: transfer complete.
 rsp_rdata  out  32  read data, valid with doneN.
 rsp_err  out  1  timeout flag, valid with doneN.
 hsel, htrans[1:0], hwrite, haddr[31:0], hwdata[31:0], hsize[2:0], hburst[2:0], hprot[3:0], hready_in  out  AHB-lite master side to the config slave.
 hready  in  1  slave ready.
 hrdata  in  32  slave read data.
REQ-003 One clock; reset is synchronous and active-high.

Function
REQ-004 FSM states IDLE, ADDR, DATA; transitions IDLE->ADDR when any reqN_vld=1, ADDR->DATA unconditionally, DATA->IDLE when hready=1 (or on timeout).
REQ-005 Arbitration in IDLE is round-robin: when both valid, grant goes to the requester not granted last; when one valid, it is granted.
REQ-006 Last-grant pointer updates only on grant.
REQ-007 In ADDR: hsel=1, htrans=2'b10, hwrite/haddr from the granted request, hsize=3'b010, hburst=3'b000, hprot=4'b0011, hready_in=1.
REQ-008 reqN_ack pulses for the granted requester in ADDR; the request is captured internally, so the requester may change or drop its inputs afterwards.
REQ-009 In DATA: hsel=0, htrans=2'b00, hwdata holds the captured write data until hready=1.
REQ-010 Outside DATA, hwdata=0.
REQ-011 Completion: on the DATA cycle with hready=1, reqN_done pulses in the following cycle, alongside rsp_rdata (hrdata sampled at that edge for reads, 0 for writes) and rsp_err=0.
REQ-012 Always at least one IDLE cycle between transfers: the minimum transfer is 3 cycles, so no back-to-back address phases.
REQ-013 A request whose reqN_vld drops before grant is not issued.
REQ-014 rsp_rdata and rsp_err hold their values until the next done.

Reset
REQ-015 While hrst=1 at a clock edge:
 - FSM=IDLE, last-grant pointer=1, so req0 wins the first tie.
 - All outputs are 0 except hready_in=1.
 - Captured request, rsp_rdata and rsp_err are 0.
REQ-016 Reset during ADDR or DATA abandons the transfer without a done pulse.

Configuration
REQ-017 Macro IVS_CFG_ARB_TIMEOUT_EN defined:
 - A counter clears on entering DATA and increments each DATA cycle with hready=0.
 - When it reaches TO_CYC, the FSM goes to IDLE and done pulses next cycle with rsp_err=1 and rsp_rdata=0.
 - hready=1 on the same cycle as the limit takes precedence (normal completion, rsp_err=0).
REQ-018 Macro undefined: no counter exists, DATA waits indefinitely, and rsp_err is tied 0.

Verification
REQ-019 req0 write, addr 0x100, data 0xA5A5_0001, hready low for 1 DATA cycle -> haddr=0x100 with htrans=2'b10 for one cycle, hwdata=0xA5A5_0001 for 2 cycles, req0_done one cycle after hready=1, rsp_err=0.
REQ-020 req1 read, addr 0x11C, slave returns 0x1234_5678 -> req1_done with rsp_rdata=0x1234_5678.
REQ-021 Both valid continuously from reset for 4 transfers -> grant order 0,1,0,1, each with exactly one ack and one done.
REQ-022 req0_vld pulsed for 1 cycle while req1 is in DATA -> req0 not issued and no req0_ack.
REQ-023 With the macro, TO_CYC=16, hready held 0 -> done after 16 DATA cycles with rsp_err=1 and rsp_rdata=0.
REQ-024 Without the macro, the same stimulus -> no done, FSM stays in DATA.
REQ-025 hrst asserted mid-DATA -> next cycle all outputs at reset values, no done, and the next tie grants req0.
